// File: rtl/imem_loader.sv
// Boot-time loader: assembles a big-endian byte stream into 32-bit words, writes them
// to instruction memory from word address 0, then releases the CPU reset.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              error,
    output logic              cpu_resetn,
    output logic [2:0]        dbg_state
);

    // Handshake: a byte moves only on a clock edge where in_valid and in_ready are both 1;
    // the source must hold in_data stable while in_valid=1 and in_ready=0.
    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0,
        S_HDR_LO = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              rdy_q;
    logic [7:0]        hdr_hi;
    logic [15:0]       n_words;
    logic [23:0]       word_buf;
    logic [1:0]        byte_idx;
    logic [ADDR_W:0]   word_idx;
    logic              xfer;
    logic [15:0]       hdr;
    logic              last_word;

    assign xfer      = in_valid & rdy_q;
    assign hdr       = {hdr_hi, in_data};
    // word_idx is one bit wider than the address so a full 2**ADDR_W program still terminates
    assign last_word = (16'(word_idx) + 16'd1) == n_words;

    always_comb begin
        state_nx = state;
        case (state)
            S_HDR_HI: if (xfer) state_nx = S_HDR_LO;
            S_HDR_LO: begin
                if (xfer) begin
                    if (hdr == 16'd0)                 state_nx = S_DONE;
                    else if (hdr > 16'(MAX_WORDS))    state_nx = S_ERR;
                    else                              state_nx = S_DATA;
                end
            end
            S_DATA:   if (xfer && byte_idx == 2'd3) state_nx = S_WRITE;
            S_WRITE:  state_nx = last_word ? S_DONE : S_DATA;
            default:  state_nx = state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_HDR_HI;
            rdy_q     <= 1'b0;
            hdr_hi    <= 8'd0;
            n_words   <= 16'd0;
            word_buf  <= 24'd0;
            byte_idx  <= 2'd0;
            word_idx  <= '0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            state <= state_nx;
            rdy_q <= (state_nx == S_HDR_HI) || (state_nx == S_HDR_LO) || (state_nx == S_DATA);
            case (state)
                S_HDR_HI: if (xfer) hdr_hi <= in_data;
                S_HDR_LO: begin
                    if (xfer) begin
                        n_words  <= hdr;
                        byte_idx <= 2'd0;
                        word_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        word_buf <= {word_buf[15:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_wdata <= {word_buf, in_data};
                            mem_addr  <= word_idx[ADDR_W-1:0];
                        end
                    end
                end
                S_WRITE: begin
                    byte_idx <= 2'd0;
                    if (!last_word) word_idx <= word_idx + {{ADDR_W{1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = rdy_q;
    assign mem_write  = (state == S_WRITE);
    assign done       = (state == S_DONE);
    assign cpu_resetn = (state == S_DONE);
    assign error      = (state == S_ERR);
    assign dbg_state  = state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: cycle-exact vector table for the basic streams, then driven
// sequences (handshake gaps, mid-load reset, full 256-word program) against a write scoreboard.
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        error;
    logic        cpu_resetn;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic        mon_on = 1'b0;
    logic [39:0] exp_q[$];
    logic [31:0] mem_model[256];
    logic [31:0] words[256];

    imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .done(done), .error(error), .cpu_resetn(cpu_resetn),
        .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        dn;
        logic        er;
        logic        cpu;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic vld, input logic [7:0] dat,
                       input logic rdy, input logic wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic dn, input logic er,
                       input logic cpu);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dat = dat; v.rdy = rdy; v.wr = wr;
        v.addr = addr; v.wdata = wdata; v.dn = dn; v.er = er; v.cpu = cpu;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [44:0] outs();
        return {in_ready, mem_write, mem_addr, mem_wdata, done, error, cpu_resetn};
    endfunction

    // Write scoreboard: every strobe must match the next expected {addr, data}.
    always @(posedge clock) begin
        #1;
        if (mon_on && mem_write) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write_data: got %h, required %h", {mem_addr, mem_wdata}, e);
                end
            end
            mem_model[mem_addr] = mem_wdata;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL write_ready: got in_ready=%b, required 0", in_ready);
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("reset_outputs", 64'(outs()), 64'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("push_timeout", 64'(in_ready), 64'd1);
        @(posedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clock);
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("done_reached", 64'(done), 64'd1);
        chk("cpu_released", 64'(cpu_resetn), 64'd1);
    endtask

    task automatic push_word(input logic [31:0] w, input int max_gap);
        for (int k = 3; k >= 0; k--) begin
            idle($urandom_range(0, max_gap));
            push(w[k*8 +: 8]);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;

        // Two-word program, source always valid
        add(1,0,8'h00, 0,0,8'd0,32'h0,        0,0,0);
        add(0,0,8'h00, 1,0,8'd0,32'h0,        0,0,0);
        add(0,1,8'h00, 1,0,8'd0,32'h0,        0,0,0);
        add(0,1,8'h02, 1,0,8'd0,32'h0,        0,0,0);
        add(0,1,8'h20, 1,0,8'd0,32'h0,        0,0,0);
        add(0,1,8'h08, 1,0,8'd0,32'h0,        0,0,0);
        add(0,1,8'h00, 1,0,8'd0,32'h0,        0,0,0);
        add(0,1,8'h05, 0,1,8'd0,32'h20080005, 0,0,0);
        add(0,1,8'h01, 1,0,8'd0,32'h20080005, 0,0,0);
        add(0,1,8'h01, 1,0,8'd0,32'h20080005, 0,0,0);
        add(0,1,8'h09, 1,0,8'd0,32'h20080005, 0,0,0);
        add(0,1,8'h50, 1,0,8'd0,32'h20080005, 0,0,0);
        add(0,1,8'h20, 0,1,8'd1,32'h01095020, 0,0,0);
        add(0,1,8'h33, 0,0,8'd1,32'h01095020, 1,0,1);
        add(0,1,8'h33, 0,0,8'd1,32'h01095020, 1,0,1);
        // Empty program
        add(1,0,8'h00, 0,0,8'd0,32'h0,        0,0,0);
        add(0,0,8'h00, 1,0,8'd0,32'h0,        0,0,0);
        add(0,1,8'h00, 1,0,8'd0,32'h0,        0,0,0);
        add(0,1,8'h00, 0,0,8'd0,32'h0,        1,0,1);
        add(0,1,8'hAA, 0,0,8'd0,32'h0,        1,0,1);
        // Oversized header 257
        add(1,0,8'h00, 0,0,8'd0,32'h0,        0,0,0);
        add(0,0,8'h00, 1,0,8'd0,32'h0,        0,0,0);
        add(0,1,8'h01, 1,0,8'd0,32'h0,        0,0,0);
        add(0,1,8'h01, 0,0,8'd0,32'h0,        0,1,0);
        add(0,1,8'h55, 0,0,8'd0,32'h0,        0,1,0);
        add(0,1,8'h55, 0,0,8'd0,32'h0,        0,1,0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            reset    = vecs[i].rst;
            in_valid = vecs[i].vld;
            in_data  = vecs[i].dat;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({vecs[i].rdy, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                     vecs[i].dn, vecs[i].er, vecs[i].cpu}));
        end

        mon_on = 1'b1;

        // One word with in_valid toggling every cycle
        do_reset();
        exp_q.push_back({8'd0, 32'hDEADBEEF});
        push(8'h00); idle(1);
        push(8'h01); idle(1);
        push(8'hDE); idle(1);
        push(8'hAD); idle(1);
        push(8'hBE); idle(1);
        push(8'hEF);
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("t4_done", 64'({done, cpu_resetn, in_ready, error}), 64'b1100);
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-load, then a fresh one-word stream
        do_reset();
        exp_q.push_back({8'd0, 32'h11223344});
        push(8'h00); push(8'h03);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'hAA); push(8'hBB);
        do_reset();
        chk("t5_first_word_seen", 64'(exp_q.size()), 64'd0);
        idle(1);
        chk("t5_ready_after_reset", 64'(in_ready), 64'd1);
        exp_q.push_back({8'd0, 32'h00000000});
        push(8'h00); push(8'h01);
        push_word(32'h00000000, 0);
        wait_done(20);
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // Full 256-word program with random source gaps
        do_reset();
        for (int i = 0; i < 256; i++) begin
            words[i] = $urandom;
            exp_q.push_back({8'(i), words[i]});
        end
        push(8'h01); push(8'h00);
        for (int i = 0; i < 256; i++) push_word(words[i], 2);
        @(negedge clock);
        in_valid = 1'b0;
        wait_done(20);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t6_error_low", 64'(error), 64'd0);
        for (int i = 0; i < 256; i++)
            chk($sformatf("t6_mem%0d", i), 64'(mem_model[i]), 64'(words[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
